// File: rtl/bus_master_arbiter_if.sv
// bus_master_arbiter_if
//   Bus-ownership handshake between the CPU control unit, the external
//   requesters and bus_master_arbiter.
//   instr_end : control unit -> arbiter, last microstep of the instruction
//   req       : requesters -> arbiter, level request per requester
//   gnt       : arbiter -> requesters, one-hot registered grant
//   ctrlen    : arbiter -> control unit, active-low ROM enable (0 = CPU owns bus)
//   busy      : arbiter status, high whenever the CPU is not the owner
//   tmo       : arbiter status, sticky hold-timeout flag
//   Modports: master = requester/control-unit side, slave = arbiter side.
interface bus_master_arbiter_if #(
    parameter int NREQ = 2
);
    logic            instr_end;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic            ctrlen;
    logic            busy;
    logic            tmo;

    modport master (output instr_end, req, input gnt, ctrlen, busy, tmo);
    modport slave  (input instr_end, req, output gnt, ctrlen, busy, tmo);
endinterface

// File: rtl/bus_master_arbiter.sv
// bus_master_arbiter
//   Shares the CPU data bus between the microcode control unit and NREQ
//   external masters. The CPU owns the bus by default; an external request is
//   only taken at an instruction boundary, with one idle turnaround cycle on
//   the way out (OFF) and on the way back (ON). Priority is round-robin.
//   Ports:
//     clk  : system clock, rising edge
//     rstn : asynchronous active-low reset
//     bus  : bus_master_arbiter_if.slave (instr_end, req in; gnt, ctrlen,
//            busy, tmo out, all outputs registered)
//   Parameters: NREQ (1..8), HOLD_MAX (1..255, timeout build only).
//   Optional feature: define ARB_TIMEOUT_EN to bound each tenure to HOLD_MAX
//   granted cycles; otherwise tmo is tied low and no counter/mask exists.
module bus_master_arbiter #(
    parameter int NREQ     = 2,
    parameter int HOLD_MAX = 255
) (
    input  logic                 clk,
    input  logic                 rstn,
    bus_master_arbiter_if.slave  bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 1 || NREQ > 8) begin : g_bad_nreq
        $error("bus_master_arbiter: NREQ must be 1..8");
    end
    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
        $error("bus_master_arbiter: HOLD_MAX must be 1..255");
    end

    typedef enum logic [1:0] {ST_CPU, ST_OFF, ST_EXT, ST_ON} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   rr_last_q, rr_last_d;
    logic [IW-1:0]   pick;
    logic            pick_vld;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            off_q;      // registered "CPU is not the owner"
    logic            owner_req;

    assign owner_req = bus.req[owner_q];

`ifdef ARB_TIMEOUT_EN
    logic [7:0]      cnt_q, cnt_d;
    logic [NREQ-1:0] mask_q, mask_d;
    logic            tmo_q, tmo_d;
    logic            hold_exp;

    // cnt only advances while gnt is actually high, so a tenure lasts
    // exactly HOLD_MAX granted cycles.
    assign hold_exp = (gnt_q != '0) && (cnt_q == 8'(HOLD_MAX - 1));
    // A timed-out requester stays out of arbitration until it drops req.
    assign elig     = bus.req & ~mask_q;
    assign bus.tmo  = tmo_q;
`else
    assign elig     = bus.req;
    assign bus.tmo  = 1'b0;
`endif

    // Round-robin pick: first eligible requester after rr_last, wrapping.
    // Scanning from the farthest offset down leaves the nearest one in pick.
    always_comb begin
        int            idx;
        logic [IW-1:0] idx_w;
        pick     = rr_last_q;
        pick_vld = 1'b0;
        idx      = 0;
        idx_w    = '0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = int'(rr_last_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            idx_w = IW'(idx);
            if (elig[idx_w]) begin
                pick     = idx_w;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        gnt_d     = '0;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        mask_d    = mask_q & bus.req;   // dropping req clears its mask bit
`endif
        case (state_q)
            ST_CPU: begin
                // off_q still high means the CPU has just got the bus back
                // and has not run a cycle yet; wait for a fresh boundary.
                if (bus.instr_end && pick_vld && !off_q) begin
                    owner_d = pick;
                    state_d = ST_OFF;
                end
            end
            ST_OFF: begin
                if (owner_req) begin
                    state_d   = ST_EXT;
                    rr_last_d = owner_q;
`ifdef ARB_TIMEOUT_EN
                    cnt_d     = '0;
                    tmo_d     = 1'b0;
`endif
                end else begin
                    state_d = ST_ON;
                end
            end
            ST_EXT: begin
`ifdef ARB_TIMEOUT_EN
                if (hold_exp) begin
                    state_d         = ST_ON;
                    tmo_d           = 1'b1;
                    mask_d[owner_q] = bus.req[owner_q];
                end else
`endif
                if (!owner_req) begin
                    state_d = ST_ON;
                end else begin
                    gnt_d[owner_q] = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    if (gnt_q != '0 && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
`endif
                end
            end
            default: state_d = ST_CPU;  // ST_ON
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_CPU;
            owner_q   <= '0;
            rr_last_q <= IW'(NREQ - 1);
            gnt_q     <= '0;
            off_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            gnt_q     <= gnt_d;
            // ctrlen follows the state one edge late: it rises the edge after
            // leaving CPU and falls one edge after returning there, framing
            // gnt with a turnaround cycle on each side.
            off_q     <= (state_q != ST_CPU);
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q  <= '0;
            mask_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            mask_q <= mask_d;
            tmo_q  <= tmo_d;
        end
    end
`endif

    assign bus.gnt    = gnt_q;
    assign bus.ctrlen = off_q;
    assign bus.busy   = off_q;
endmodule

// File: tb/tb_bus_master_arbiter.sv
module tb_bus_master_arbiter;
    logic clk;
    logic rstn;

    bus_master_arbiter_if #(.NREQ(2)) bus ();

    bus_master_arbiter #(.NREQ(2), .HOLD_MAX(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [1:0] exp_q[$];      // expected grant vector per tenure
    logic [1:0] prev_gnt = 2'b00;
    int         rr_m = 1;      // model of the last granted requester

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Two-requester round-robin reference; records the winner as last granted.
    function automatic logic [1:0] model_pick(input logic [1:0] r);
        logic [1:0] w;
        if (rr_m == 0) w = r[1] ? 2'b10 : (r[0] ? 2'b01 : 2'b00);
        else           w = r[0] ? 2'b01 : (r[1] ? 2'b10 : 2'b00);
        if (w == 2'b01) rr_m = 0;
        if (w == 2'b10) rr_m = 1;
        return w;
    endfunction

    // Scoreboard + invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (rstn) begin
            check("gnt_onehot", 32'($onehot0(bus.gnt)), 32'd1);
            check("gnt_while_cpu", 32'(bus.gnt != 2'b00 && bus.ctrlen == 1'b0), 32'd0);
            if (bus.gnt != 2'b00 && prev_gnt == 2'b00) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_unexpected: gnt=%b, no grant expected", bus.gnt);
                end else begin
                    check("sb_gnt", 32'(bus.gnt), 32'(exp_q.pop_front()));
                end
            end
            prev_gnt <= bus.gnt;
        end else begin
            prev_gnt <= 2'b00;
        end
    end

    task automatic step(input logic [1:0] r, input logic ie);
        @(negedge clk);
        bus.req       = r;
        bus.instr_end = ie;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cpu(input string name, input logic [1:0] r);
        int n = 0;
        while (bus.ctrlen !== 1'b0 && n < 10) begin
            step(r, 1'b0);
            n++;
        end
        check(name, 32'(bus.ctrlen), 32'd0);
    endtask

    task automatic tenure(input logic [1:0] r, input int hold);
        logic [1:0] w;
        w = model_pick(r);
        exp_q.push_back(w);
        step(r, 1'b1);
        repeat (hold + 1) step(r, 1'b0);
        check("tenure_gnt", 32'(bus.gnt), 32'(w));
        step(2'b00, 1'b0);
        check("tenure_drop", 32'(bus.gnt), 32'd0);
        wait_cpu("tenure_cpu", 2'b00);
    endtask

    typedef struct {
        logic [1:0] req;
        logic       ie;
        logic [1:0] push;
        logic [1:0] gnt;
        logic       ctrlen;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int hold_n;
        // single grant, then a withdrawn request; busy tracks ctrlen
        tbl[0]  = '{2'b01, 1'b1, 2'b01, 2'b00, 1'b0};
        tbl[1]  = '{2'b01, 1'b0, 2'b00, 2'b00, 1'b1};
        tbl[2]  = '{2'b01, 1'b0, 2'b00, 2'b01, 1'b1};
        tbl[3]  = '{2'b01, 1'b0, 2'b00, 2'b01, 1'b1};
        tbl[4]  = '{2'b00, 1'b0, 2'b00, 2'b00, 1'b1};
        tbl[5]  = '{2'b00, 1'b0, 2'b00, 2'b00, 1'b1};
        tbl[6]  = '{2'b00, 1'b0, 2'b00, 2'b00, 1'b0};
        tbl[7]  = '{2'b10, 1'b1, 2'b00, 2'b00, 1'b0};
        tbl[8]  = '{2'b00, 1'b0, 2'b00, 2'b00, 1'b1};
        tbl[9]  = '{2'b00, 1'b0, 2'b00, 2'b00, 1'b1};
        tbl[10] = '{2'b00, 1'b0, 2'b00, 2'b00, 1'b0};

        rstn          = 1'b0;
        bus.req       = 2'b11;
        bus.instr_end = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_ctrlen", 32'(bus.ctrlen), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_tmo", 32'(bus.tmo), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(2'b11, 1'b0);
            check("idle_gnt", 32'(bus.gnt), 32'd0);
            check("idle_busy", 32'(bus.busy), 32'd0);
        end

        for (int i = 0; i < 11; i++) begin
            if (tbl[i].push != 2'b00) exp_q.push_back(tbl[i].push);
            step(tbl[i].req, tbl[i].ie);
            check($sformatf("vec%0d_gnt", i), 32'(bus.gnt), 32'(tbl[i].gnt));
            check($sformatf("vec%0d_ctrlen", i), 32'(bus.ctrlen), 32'(tbl[i].ctrlen));
            check($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(tbl[i].ctrlen));
        end
        rr_m = 0;  // requester 0 held the only real tenure in the table

        // withdrawn request must not have rotated priority: 11 grants 10 first,
        // then grants alternate
        tenure(2'b11, 2);
        tenure(2'b11, 1);
        tenure(2'b11, 1);
        tenure(2'b11, 3);

`ifdef ARB_TIMEOUT_EN
        exp_q.push_back(model_pick(2'b01));
        step(2'b01, 1'b1);
        step(2'b01, 1'b0);
        hold_n = 0;
        for (int i = 0; i < 10; i++) begin
            step(2'b01, 1'b0);
            if (bus.gnt == 2'b01) hold_n++;
        end
        check("tmo_hold_cycles", 32'(hold_n), 32'd4);
        check("tmo_set", 32'(bus.tmo), 32'd1);
        wait_cpu("tmo_cpu", 2'b01);
        step(2'b01, 1'b1);
        repeat (3) step(2'b01, 1'b0);
        check("tmo_masked_busy", 32'(bus.busy), 32'd0);
        check("tmo_sticky", 32'(bus.tmo), 32'd1);
        step(2'b00, 1'b0);
        exp_q.push_back(model_pick(2'b01));
        step(2'b01, 1'b1);
        step(2'b01, 1'b0);
        check("tmo_clear", 32'(bus.tmo), 32'd0);
        step(2'b01, 1'b0);
        check("tmo_regrant", 32'(bus.gnt), 32'd1);
        step(2'b00, 1'b0);
        wait_cpu("tmo_regrant_cpu", 2'b00);
`else
        hold_n = 0;
        check("tmo_tied", 32'(bus.tmo), 32'(hold_n));
`endif

        // reset in the middle of a tenure held by requester 1
        exp_q.push_back(model_pick(2'b10));
        step(2'b10, 1'b1);
        step(2'b10, 1'b0);
        step(2'b10, 1'b0);
        check("mid_gnt", 32'(bus.gnt), 32'd2);
        step(2'b10, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        check("mid_rst_gnt", 32'(bus.gnt), 32'd0);
        check("mid_rst_ctrlen", 32'(bus.ctrlen), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rstn    = 1'b1;
        bus.req = 2'b00;
        rr_m    = 1;
        step(2'b00, 1'b0);
        check("post_rst_busy", 32'(bus.busy), 32'd0);
        tenure(2'b11, 1);  // reset priority favours requester 0

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
